// File: rtl/fifo_rd_checker_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_checker_if
// Read-port bundle between a FIFO and its read-side consumer.
//   rd_en : read enable, driven by the consumer
//   empty : FIFO empty flag, driven by the FIFO
//   dout  : FIFO read data, driven by the FIFO
// Modports:
//   master : consumer side (drives rd_en, observes empty/dout)
//   slave  : FIFO side (observes rd_en, drives empty/dout)
// ---------------------------------------------------------------------------
interface fifo_rd_checker_if #(
  parameter int DOUT_WIDTH = 8
) ();

  logic                  rd_en;
  logic                  empty;
  logic [DOUT_WIDTH-1:0] dout;

  modport master (
    output rd_en,
    input  empty,
    input  dout
  );

  modport slave (
    input  rd_en,
    output empty,
    output dout
  );

endinterface

// File: rtl/fifo_rd_checker.sv
// ---------------------------------------------------------------------------
// fifo_rd_checker
// Read-side consumer that drains NUM_WORDS words from a FIFO and checks them
// against the incrementing pattern 0,1,2,... (mod 2^DOUT_WIDTH). Supports
// first-word-fall-through (FWFT_EN=1) and one-cycle read latency (FWFT_EN=0),
// with an optional idle gap of RD_GAP cycles after every read.
//
// Ports:
//   rd_clk    : clock, all logic on the rising edge
//   rd_rst_n  : asynchronous active-low reset
//   start     : one-cycle run request, honoured only in IDLE or DONE
//   rd_if     : FIFO read port (rd_en out, empty/dout in)
//   busy      : high while reading (READ or GAP)
//   done      : high in DONE until the next accepted start
//   err       : sticky mismatch flag for the current run
//   err_cnt   : saturating mismatch count
//   rd_cnt    : words checked in the current run
//   first_bad : data value at the first mismatch of the run (0 if none)
// ---------------------------------------------------------------------------
module fifo_rd_checker #(
  parameter int DOUT_WIDTH = 8,
  parameter int FWFT_EN    = 1,
  parameter int NUM_WORDS  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_GAP     = 0
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  start,
  fifo_rd_checker_if.master     rd_if,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [DOUT_WIDTH-1:0] first_bad
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic                  FWFT_C      = (FWFT_EN != 32'sd0);
  localparam logic                  GAP_EN_C    = (RD_GAP > 32'sd0);
  localparam int                    GAP_W       = (RD_GAP > 32'sd2) ? $clog2(RD_GAP) : 1;
  localparam logic [GAP_W-1:0]      GAP_LOAD_C  = GAP_W'((RD_GAP > 32'sd0) ? (RD_GAP - 32'sd1) : 32'sd0);
  localparam logic [GAP_W-1:0]      GAP_ZERO_C  = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]      GAP_ONE_C   = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  NUM_WORDS_C = CNT_WIDTH'(NUM_WORDS);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO_C  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE_C   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX_C   = {CNT_WIDTH{1'b1}};
  localparam logic [DOUT_WIDTH-1:0] DAT_ZERO_C  = {DOUT_WIDTH{1'b0}};
  localparam logic [DOUT_WIDTH-1:0] DAT_ONE_C   = {{(DOUT_WIDTH-1){1'b0}}, 1'b1};

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
    logic [CNT_WIDTH-1:0] res;
    if (val == CNT_MAX_C) begin
      res = CNT_MAX_C;
    end else begin
      res = val + CNT_ONE_C;
    end
    return res;
  endfunction

  state_e                state_q,     state_d;
  logic [CNT_WIDTH-1:0]  iss_cnt_q,   iss_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q,   gap_cnt_d;
  logic                  chk_q,       chk_d;
  logic [DOUT_WIDTH-1:0] exp_q,       exp_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q,    rd_cnt_d;
  logic                  err_q,       err_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q,   err_cnt_d;
  logic [DOUT_WIDTH-1:0] first_bad_q, first_bad_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;

  logic rd_en_s;
  logic chk_s;
  logic start_ok_s;
  logic mismatch_s;

  // Read enable: only in READ, never while empty, never past the issue budget.
  always_comb begin
    rd_en_s = 1'b0;
    if ((state_q == ST_READ) && !rd_if.empty && (iss_cnt_q < NUM_WORDS_C)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  assign rd_if.rd_en = rd_en_s;

  // Check strobe: same cycle as rd_en for FWFT, one cycle later otherwise.
  always_comb begin
    chk_d      = rd_en_s;
    start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    if (FWFT_C) begin
      chk_s = rd_en_s;
    end else begin
      chk_s = chk_q;
    end
  end

  // Compare datapath: run-clear on start, otherwise update on every check strobe.
  always_comb begin
    exp_d       = exp_q;
    rd_cnt_d    = rd_cnt_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    first_bad_d = first_bad_q;
    mismatch_s  = 1'b0;
    if (start_ok_s) begin
      exp_d       = DAT_ZERO_C;
      rd_cnt_d    = CNT_ZERO_C;
      err_d       = 1'b0;
      err_cnt_d   = CNT_ZERO_C;
      first_bad_d = DAT_ZERO_C;
    end else if (chk_s) begin
      mismatch_s = (rd_if.dout != exp_q);
      if (mismatch_s) begin
        err_d     = 1'b1;
        err_cnt_d = sat_inc(err_cnt_q);
        // Only the first mismatch of a run is captured.
        if (!err_q) begin
          first_bad_d = rd_if.dout;
        end else begin
          first_bad_d = first_bad_q;
        end
      end else begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
      end
      // The expected value advances even on a mismatch so one bad word
      // does not cascade into errors on every later word.
      exp_d    = exp_q + DAT_ONE_C;
      rd_cnt_d = rd_cnt_q + CNT_ONE_C;
    end else begin
      exp_d    = exp_q;
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Next-state logic, issue counter and gap counter.
  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_READ;
          iss_cnt_d = CNT_ZERO_C;
          gap_cnt_d = GAP_ZERO_C;
        end else begin
          state_d = state_q;
        end
      end
      ST_READ: begin
        if (rd_en_s) begin
          iss_cnt_d = iss_cnt_q + CNT_ONE_C;
        end else begin
          iss_cnt_d = iss_cnt_q;
        end
        // Completion uses the updated count so FWFT finishes on the last read.
        if (rd_cnt_d == NUM_WORDS_C) begin
          state_d = ST_DONE;
        end else if (rd_en_s && GAP_EN_C) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD_C;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_GAP: begin
        if (rd_cnt_d == NUM_WORDS_C) begin
          state_d = ST_DONE;
        end else if (gap_cnt_q == GAP_ZERO_C) begin
          state_d = ST_READ;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = gap_cnt_q - GAP_ONE_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they track the state register.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_READ, ST_GAP: begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      ST_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset also drops any pending check strobe.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= ST_IDLE;
      iss_cnt_q   <= CNT_ZERO_C;
      gap_cnt_q   <= GAP_ZERO_C;
      chk_q       <= 1'b0;
      exp_q       <= DAT_ZERO_C;
      rd_cnt_q    <= CNT_ZERO_C;
      err_q       <= 1'b0;
      err_cnt_q   <= CNT_ZERO_C;
      first_bad_q <= DAT_ZERO_C;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iss_cnt_q   <= iss_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      chk_q       <= chk_d;
      exp_q       <= exp_d;
      rd_cnt_q    <= rd_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      first_bad_q <= first_bad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign first_bad = first_bad_q;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_checker
// Directed bench for fifo_rd_checker. Three instances share clock and reset:
//   A : FWFT, no gap, 16 words  (clean, corrupted, mid-run reset)
//   B : standard latency, no gap, 300 words (wrap, latency, corrupted word)
//   C : FWFT, RD_GAP=2, 16 words with a toggling empty flag
// Each instance has a small behavioural FIFO model driving its interface.
// ---------------------------------------------------------------------------
module tb_fifo_rd_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic        busy_a, done_a, err_a;
  logic [15:0] err_cnt_a, rd_cnt_a;
  logic [7:0]  first_bad_a;
  logic        busy_b, done_b, err_b;
  logic [15:0] err_cnt_b, rd_cnt_b;
  logic [7:0]  first_bad_b;
  logic        busy_c, done_c, err_c;
  logic [15:0] err_cnt_c, rd_cnt_c;
  logic [7:0]  first_bad_c;

  fifo_rd_checker_if #(.DOUT_WIDTH(8)) if_a ();
  fifo_rd_checker_if #(.DOUT_WIDTH(8)) if_b ();
  fifo_rd_checker_if #(.DOUT_WIDTH(8)) if_c ();

  fifo_rd_checker #(.DOUT_WIDTH(8), .FWFT_EN(1), .NUM_WORDS(16), .CNT_WIDTH(16), .RD_GAP(0)) u_a (
    .rd_clk(clk), .rd_rst_n(rst_n), .start(start_a), .rd_if(if_a.master),
    .busy(busy_a), .done(done_a), .err(err_a), .err_cnt(err_cnt_a),
    .rd_cnt(rd_cnt_a), .first_bad(first_bad_a));

  fifo_rd_checker #(.DOUT_WIDTH(8), .FWFT_EN(0), .NUM_WORDS(300), .CNT_WIDTH(16), .RD_GAP(0)) u_b (
    .rd_clk(clk), .rd_rst_n(rst_n), .start(start_b), .rd_if(if_b.master),
    .busy(busy_b), .done(done_b), .err(err_b), .err_cnt(err_cnt_b),
    .rd_cnt(rd_cnt_b), .first_bad(first_bad_b));

  fifo_rd_checker #(.DOUT_WIDTH(8), .FWFT_EN(1), .NUM_WORDS(16), .CNT_WIDTH(16), .RD_GAP(2)) u_c (
    .rd_clk(clk), .rd_rst_n(rst_n), .start(start_c), .rd_if(if_c.master),
    .busy(busy_c), .done(done_c), .err(err_c), .err_cnt(err_cnt_c),
    .rd_cnt(rd_cnt_c), .first_bad(first_bad_c));

  // FIFO models and read monitors
  int cyc = 0;
  logic clr_a = 1'b1, clr_b = 1'b1, clr_c = 1'b1;

  logic [7:0] mem_a [0:31];
  logic [9:0] avail_a = 10'd0, ptr_a = 10'd0;
  int n_rd_a = 0, first_rd_a = 0, last_rd_a = 0, viol_a = 0;

  logic [9:0] avail_b = 10'd0, ptr_b = 10'd0, bad_b = 10'h3FF;
  logic [7:0] dout_b = 8'd0;
  int n_rd_b = 0, last_rd_b = 0, viol_b = 0;

  logic [9:0] avail_c = 10'd0, ptr_c = 10'd0;
  logic [1:0] g_c = 2'd0;
  logic       gate_c = 1'b0;
  int n_rd_c = 0, last_rd_c = 0, viol_c = 0, min_gap_c = 1000;

  assign if_a.empty = (ptr_a >= avail_a);
  assign if_a.dout  = mem_a[ptr_a[4:0]];
  assign if_b.empty = (ptr_b >= avail_b);
  assign if_b.dout  = dout_b;
  assign if_c.empty = (ptr_c >= avail_c) || gate_c;
  assign if_c.dout  = ptr_c[7:0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    // A: FWFT model, data visible at the read pointer
    if (if_a.rd_en && if_a.empty) viol_a <= viol_a + 1;
    if (clr_a) begin
      ptr_a <= 10'd0; n_rd_a <= 0;
    end else if (if_a.rd_en) begin
      ptr_a <= ptr_a + 10'd1;
      n_rd_a <= n_rd_a + 1;
      if (n_rd_a == 0) first_rd_a <= cyc + 1;
      last_rd_a <= cyc + 1;
    end
    // B: standard model, data registered on the read edge
    if (if_b.rd_en && if_b.empty) viol_b <= viol_b + 1;
    if (clr_b) begin
      ptr_b <= 10'd0; n_rd_b <= 0;
    end else if (if_b.rd_en) begin
      dout_b <= (ptr_b == bad_b) ? 8'hAA : ptr_b[7:0];
      ptr_b <= ptr_b + 10'd1;
      n_rd_b <= n_rd_b + 1;
      last_rd_b <= cyc + 1;
    end
    // C: empty gate toggles every 3 cycles, data trickles in every 2 cycles
    if (g_c == 2'd2) begin
      g_c <= 2'd0; gate_c <= ~gate_c;
    end else begin
      g_c <= g_c + 2'd1;
    end
    if (if_c.rd_en && if_c.empty) viol_c <= viol_c + 1;
    if (clr_c) begin
      ptr_c <= 10'd0; avail_c <= 10'd1; n_rd_c <= 0; min_gap_c <= 1000;
    end else begin
      if ((cyc % 2 == 0) && (avail_c < 10'd64)) avail_c <= avail_c + 10'd1;
      if (if_c.rd_en) begin
        ptr_c <= ptr_c + 10'd1;
        n_rd_c <= n_rd_c + 1;
        if ((n_rd_c != 0) && ((cyc + 1 - last_rd_c) < min_gap_c)) min_gap_c <= cyc + 1 - last_rd_c;
        last_rd_c <= cyc + 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int sel, input int max_cyc, input string tag, output int at);
    logic d;
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      d = (sel == 0) ? done_a : ((sel == 1) ? done_b : done_c);
      if (d) begin
        at = cyc;
        return;
      end
      tick();
    end
    d = (sel == 0) ? done_a : ((sel == 1) ? done_b : done_c);
    check_val(tag, 32'(d), 32'd1);
  endtask

  task automatic run_a(input string tag, output int st, output int at);
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    st = cyc;
    check_val({tag, "_busy"}, 32'(busy_a), 32'd1);
    wait_done(0, 100, {tag, "_timeout"}, at);
  endtask

  int st, at;

  initial begin
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(i);
    avail_a = 10'd16;
    tick(); tick(); tick();
    // reset state, FIFO A holds data yet nothing is read
    check_val("rst_rd_en",  32'(if_a.rd_en), 32'd0);
    check_val("rst_busy",   32'(busy_a), 32'd0);
    check_val("rst_done",   32'(done_a), 32'd0);
    check_val("rst_err",    32'(err_a), 32'd0);
    check_val("rst_errcnt", 32'(err_cnt_a), 32'd0);
    check_val("rst_rdcnt",  32'(rd_cnt_a), 32'd0);
    check_val("rst_fbad",   32'(first_bad_a), 32'd0);
    rst_n = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    tick();
    check_val("idle_rd_en", 32'(if_a.rd_en), 32'd0);

    // A clean run: 16 back-to-back reads, done after the 16th read edge
    run_a("a1", st, at);
    check_val("a1_first_rd", 32'(first_rd_a), 32'(st + 1));
    check_val("a1_last_rd",  32'(last_rd_a), 32'(st + 16));
    check_val("a1_done_at",  32'(at), 32'(st + 16));
    check_val("a1_nrd",      32'(n_rd_a), 32'd16);
    check_val("a1_err",      32'(err_a), 32'd0);
    check_val("a1_rdcnt",    32'(rd_cnt_a), 32'd16);
    check_val("a1_fbad",     32'(first_bad_a), 32'd0);
    // more data arrives while DONE: no further reads, done holds
    avail_a = 10'd20;
    tick(); tick(); tick();
    check_val("a1_hold_done", 32'(done_a), 32'd1);
    check_val("a1_hold_nrd",  32'(n_rd_a), 32'd16);

    // A with word 3 corrupted to 7
    avail_a = 10'd16;
    mem_a[3] = 8'd7;
    run_a("a2", st, at);
    check_val("a2_err",    32'(err_a), 32'd1);
    check_val("a2_errcnt", 32'(err_cnt_a), 32'd1);
    check_val("a2_fbad",   32'(first_bad_a), 32'd7);
    check_val("a2_rdcnt",  32'(rd_cnt_a), 32'd16);

    // two corrupted words: count both, keep the first
    mem_a[9] = 8'd200;
    run_a("a3", st, at);
    check_val("a3_errcnt", 32'(err_cnt_a), 32'd2);
    check_val("a3_fbad",   32'(first_bad_a), 32'd7);

    // clean again without reset: start clears the error state
    mem_a[3] = 8'd3; mem_a[9] = 8'd9;
    run_a("a4", st, at);
    check_val("a4_err",    32'(err_a), 32'd0);
    check_val("a4_errcnt", 32'(err_cnt_a), 32'd0);
    check_val("a4_fbad",   32'(first_bad_a), 32'd0);

    // reset after 5 reads (word 2 corrupted so err is already set)
    mem_a[2] = 8'd99;
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 50 && n_rd_a < 5; i++) tick();
    check_val("a5_nrd5",  32'(n_rd_a), 32'd5);
    check_val("a5_pre_err", 32'(err_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("a5_rst_rd_en", 32'(if_a.rd_en), 32'd0);
    check_val("a5_rst_busy",  32'(busy_a), 32'd0);
    check_val("a5_rst_rdcnt", 32'(rd_cnt_a), 32'd0);
    check_val("a5_rst_err",   32'(err_a), 32'd0);
    check_val("a5_rst_errcnt", 32'(err_cnt_a), 32'd0);
    check_val("a5_rst_fbad",  32'(first_bad_a), 32'd0);
    tick();
    rst_n = 1'b1;
    mem_a[2] = 8'd2;
    run_a("a6", st, at);
    check_val("a6_done_at", 32'(at), 32'(st + 16));
    check_val("a6_err",     32'(err_a), 32'd0);
    check_val("a6_rdcnt",   32'(rd_cnt_a), 32'd16);

    // B: 300 words, one-cycle latency, data wraps 255->0
    avail_b = 10'd300;
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    st = cyc;
    check_val("b1_busy", 32'(busy_b), 32'd1);
    wait_done(1, 400, "b1_timeout", at);
    check_val("b1_last_rd", 32'(last_rd_b), 32'(st + 300));
    check_val("b1_done_at", 32'(at), 32'(st + 301));
    check_val("b1_nrd",     32'(n_rd_b), 32'd300);
    check_val("b1_err",     32'(err_b), 32'd0);
    check_val("b1_rdcnt",   32'(rd_cnt_b), 32'd300);

    // B with word 260 (expected 4) replaced by 0xAA
    bad_b = 10'd260;
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done(1, 400, "b2_timeout", at);
    check_val("b2_err",    32'(err_b), 32'd1);
    check_val("b2_errcnt", 32'(err_cnt_b), 32'd1);
    check_val("b2_fbad",   32'(first_bad_b), 32'd170);
    check_val("b2_rdcnt",  32'(rd_cnt_b), 32'd300);

    // C: throttled reads with toggling empty
    clr_c = 1'b1; tick(); clr_c = 1'b0;
    start_c = 1'b1; tick(); start_c = 1'b0;
    wait_done(2, 300, "c1_timeout", at);
    check_val("c1_done_at",  32'(at), 32'(last_rd_c));
    check_val("c1_nrd",      32'(n_rd_c), 32'd16);
    check_val("c1_gap_ge3",  32'(min_gap_c >= 3), 32'd1);
    check_val("c1_err",      32'(err_c), 32'd0);
    check_val("c1_rdcnt",    32'(rd_cnt_c), 32'd16);

    // no read ever issued against an empty FIFO
    check_val("viol_a", 32'(viol_a), 32'd0);
    check_val("viol_b", 32'(viol_b), 32'd0);
    check_val("viol_c", 32'(viol_c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
# fifo_rd_checker

Self-checking read-side consumer for the FIFO block: drains a configurable number of words through the FIFO read port and checks them against the incrementing pattern (0, 1, 2, … mod 2^DOUT_WIDTH) that the write-side stimulus produces. It sits in the read clock domain, directly on `rd_en`/`dout`/`empty`. It supports both first-word-fall-through and standard read latency, and optional read throttling. Used in benches and on-board bring-up to prove FIFO ordering and empty handling without a reference IP.

## Interface
Parameters:
- `DOUT_WIDTH`, 8: FIFO read data width; also the expected-pattern width.
- `FWFT_EN`, 1: 1 = `dout` is valid in the same cycle as `rd_en`; 0 = `dout` is valid one cycle after `rd_en`.
- `NUM_WORDS`, 16: words consumed per run, ≥1.
- `CNT_WIDTH`, 16: width of `rd_cnt`/`err_cnt`; NUM_WORDS < 2^CNT_WIDTH.
- `RD_GAP`, 0: idle cycles inserted after every read; 0 = back-to-back reads.

Ports:
- `rd_clk`, in, 1: single clock; all logic is on its rising edge.
- `rd_rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle run request; accepted only in IDLE or DONE.
- `empty`, in, 1: FIFO empty flag.
- `dout`, in, DOUT_WIDTH: FIFO read data.
- `rd_en`, out, 1: FIFO read enable; combinational from state, `empty` and issue count.
- `busy`, out, 1: high in READ or GAP.
- `done`, out, 1: high in DONE; stays high until the next accepted `start`.
- `err`, out, 1: sticky mismatch flag for the current run.
- `err_cnt`, out, CNT_WIDTH: mismatch count; saturates at all-ones.
- `rd_cnt`, out, CNT_WIDTH: words checked in the current run.
- `first_bad`, out, DOUT_WIDTH: `dout` value at the first mismatch of the run; 0 if there was none.

## Operation
- States: IDLE, READ, GAP, DONE.
- IDLE/DONE + `start`:
  - clear `rd_cnt`, `err`, `err_cnt`, `first_bad`, the issue counter `iss_cnt` and the expected value `exp`;
  - go to READ.
- READ:
  - `rd_en` = `~empty && iss_cnt < NUM_WORDS`.
  - On `rd_en`: `iss_cnt`++.
  - If RD_GAP > 0, go to GAP and load the gap counter with RD_GAP-1.
  - If `empty`, hold in READ with no read.
- GAP:
  - `rd_en` = 0.
  - Count down; at 0, return to READ.
- Check strobe `chk`:
  - FWFT_EN=1: `chk` = `rd_en`.
  - FWFT_EN=0: `chk` = `rd_en` registered by one cycle.
- On `chk`:
  - compare `dout` with `exp`;
  - on mismatch: `err` set; `err_cnt`++ (saturating); `first_bad` captured only if `err` was 0;
  - `exp` <= `exp`+1, wrapping mod 2^DOUT_WIDTH;
  - `rd_cnt`++.
- Run completion: when `rd_cnt` reaches NUM_WORDS (updated count), go to DONE from READ or GAP.
- `start` is ignored in READ and GAP.
- After `iss_cnt` = NUM_WORDS, no further `rd_en` is issued, regardless of `empty`.

## Timing
- Reset values: state IDLE, `rd_en` 0, `busy` 0, `done` 0, `err` 0, `err_cnt` 0, `rd_cnt` 0, `first_bad` 0, `exp` 0.
- `rd_en` falls in the same delta as the asynchronous reset assertion.
- `start` at edge N → `busy`=1 after edge N.
- First `rd_en` is possible in cycle N+1 if `empty`=0.
- Read rate:
  - RD_GAP=0, FIFO never empty: one read per cycle.
  - Otherwise: one read per RD_GAP+1 cycles.
- `done` rise relative to the last `rd_en` edge:
  - FWFT_EN=1: after that same edge.
  - FWFT_EN=0: one edge later.
- `rd_en` never asserts while `empty`=1, in any state. No reads occur when the FIFO is empty.
- `empty` rising in the same cycle as a pending read: no read that cycle; the state machine waits in READ.
- Reset mid-run: immediate return to IDLE, counters cleared, pending check strobe discarded.
- FWFT_EN=0, last read at edge M: the DONE transition happens at edge M+1, and `chk` at M+1 is still counted.

## Test plan
- NUM_WORDS=16, FWFT_EN=1, RD_GAP=0; FIFO holds 0..15; `start` → 16 back-to-back `rd_en`; `done`=1 the edge after the 16th; `err`=0, `rd_cnt`=16.
- Same with FWFT_EN=0 → `done` one cycle later than the FWFT case; `err`=0.
- FIFO holds 0,1,2,7,4,5,… (word 3 corrupted); NUM_WORDS=16 → `err`=1, `err_cnt`=1, `first_bad`=7; later words still match because `exp` advances regardless.
- `empty` toggles every 3 cycles while data is trickled in; RD_GAP=2 → `rd_en` is never high while `empty`=1; reads are ≥3 cycles apart; `done` after 16 reads.
- NUM_WORDS=300, DOUT_WIDTH=8, incrementing data wrapping 255→0 → no errors; `rd_cnt`=300.
- `rd_rst_n` pulsed low after 5 reads → all outputs return to reset values immediately; a new `start` completes a clean 16-word run with `exp` starting at 0.
